// File: rtl/memory_stage_if.sv
// Data-memory port between the memory stage (master) and the memory (slave).
// Request fields stay stable from memReq rising until memReady.
interface memory_stage_if #(
  parameter int DATA_W = 16
);
  logic              memReq;
  logic              memWe;
  logic [DATA_W-1:0] memAddr;
  logic [DATA_W-1:0] memWrDataO;
  logic [DATA_W-1:0] memRdData;
  logic              memReady;

  modport master (
    output memReq, memWe, memAddr, memWrDataO,
    input  memRdData, memReady
  );

  modport slave (
    input  memReq, memWe, memAddr, memWrDataO,
    output memRdData, memReady
  );
endinterface

// File: rtl/memory_stage.sv
// MEM stage: variable-latency memory access, write-back select, MEM/WB register.
// Optional MEM_ALIGN_CHK_EN rejects odd addresses with an error bubble.
module memory_stage #(
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] aluOut,
  input  logic [DATA_W-1:0] wrData,
  input  logic [DATA_W-1:0] setVal,
  input  logic [DATA_W-1:0] nextPc,
  input  logic              memEn,
  input  logic              memWrt,
  input  logic              regWrt,
  input  logic [2:0]        regWrtSrc,
  input  logic [2:0]        writeReg,
  input  logic              halt,
  input  logic              errIn,
  memory_stage_if.master    mem,
  output logic              stall,
  output logic [DATA_W-1:0] wbData,
  output logic              regWrtOut,
  output logic [2:0]        writeRegOut,
  output logic              haltOut,
  output logic              err
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              reg_wrt_q, reg_wrt_d;
  logic [2:0]        write_reg_q, write_reg_d;
  logic              halt_q, halt_d;
  logic              err_q, err_d;

  logic              req_raw, stall_raw;
  logic              capture, bad_err;
  logic              misalign, bad_src;
  logic [DATA_W-1:0] wb_sel;

`ifdef MEM_ALIGN_CHK_EN
  assign misalign = memEn & aluOut[0];
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    wb_sel  = '0;
    bad_src = 1'b0;
    unique case (regWrtSrc)
      3'd0:    wb_sel = aluOut;
      3'd1:    wb_sel = mem.memRdData;
      3'd2:    wb_sel = setVal;
      3'd3:    wb_sel = nextPc;
      default: bad_src = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_raw   = 1'b0;
    stall_raw = 1'b0;
    capture   = 1'b0;
    bad_err   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (memEn && !misalign) begin
          req_raw = 1'b1;
          if (mem.memReady) begin
            capture = 1'b1;
          end else begin
            stall_raw = 1'b1;
            state_d   = BUSY;
            cnt_d     = 8'd1;
          end
        end else if (misalign) begin
          bad_err = 1'b1;
        end else begin
          capture = 1'b1;
        end
      end
      BUSY: begin
        if (mem.memReady) begin
          req_raw = 1'b1;
          capture = 1'b1;
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else if (cnt_q == 8'(MAX_WAIT)) begin
          // hung memory: abandon the access and flag it downstream
          bad_err = 1'b1;
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else begin
          req_raw   = 1'b1;
          stall_raw = 1'b1;
          cnt_d     = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_comb begin
    wb_data_d   = '0;
    reg_wrt_d   = 1'b0;
    write_reg_d = '0;
    halt_d      = 1'b0;
    err_d       = bad_err;
    if (capture) begin
      wb_data_d   = wb_sel;
      reg_wrt_d   = regWrt;
      write_reg_d = writeReg;
      halt_d      = halt;
      err_d       = errIn | bad_src;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wb_data_q   <= '0;
      reg_wrt_q   <= 1'b0;
      write_reg_q <= '0;
      halt_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wb_data_q   <= wb_data_d;
      reg_wrt_q   <= reg_wrt_d;
      write_reg_q <= write_reg_d;
      halt_q      <= halt_d;
      err_q       <= err_d;
    end
  end

  // reset must kill a pending request at once, even with memEn held
  assign mem.memReq     = req_raw & ~rst;
  assign mem.memWe      = req_raw & ~rst & memWrt;
  assign mem.memAddr    = aluOut;
  assign mem.memWrDataO = wrData;
  assign stall          = stall_raw & ~rst;

  assign wbData      = wb_data_q;
  assign regWrtOut   = reg_wrt_q;
  assign writeRegOut = write_reg_q;
  assign haltOut     = halt_q;
  assign err         = err_q;

endmodule
